sel_stream_mux: RTL and testbench
=================================

Name: sel_stream_mux

Overview:
- Parametrised N:1 registered selector for the 32-bit datapath; the next generation of the 4:1 combinational selector.
- Adds valid/ready handshakes on every input and on the output, a one-deep output register, and two selection modes: explicit select and round-robin.
- Sits between multiple producers (ALU result, load data, immediate, PC+4 paths) and a single consumer stage that may stall.

Parameters:
- WIDTH, 32, data width per channel.
- NUM_IN, 4, number of input channels; must be >= 2.
- SEL_W, $clog2(NUM_IN), select/index width; derived, must not be overridden.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  0 = explicit select, 1 = round-robin.
- sel  in  SEL_W  channel index used when mode=0.
- in_data  in  NUM_IN*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_IN  per-channel valid.
- in_ready  out  NUM_IN  per-channel ready; at most one bit is high.
- out_data  out  WIDTH  registered selected data.
- out_src  out  SEL_W  index of the channel that produced out_data.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer ready.

Behaviour:
- Reset: synchronous, active-high.
  - Sets out_valid=0, out_data=0, out_src=0 and rr_ptr=0.
  - Any held beat is dropped; in_ready is all-0 during the reset cycle.
- Load enable: load_en = !out_valid || out_ready.
- Explicit mode (mode=0):
  - Candidate channel = sel.
  - If sel >= NUM_IN (non-power-of-2 NUM_IN), there is no candidate and nothing is granted.
- Round-robin mode (mode=1):
  - Candidate = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ..., NUM_IN-1, 0, ..., rr_ptr-1.
  - No valid input means no candidate.
- Grant and ready:
  - in_ready[c] = load_en for the candidate c only; all other in_ready bits are 0.
  - In explicit mode, in_ready[sel] is driven even when in_valid[sel]=0 (ready does not depend on own valid).
  - In round-robin mode, only a valid channel is ever a candidate.
- Transfer: a transfer occurs when in_valid[c] && in_ready[c]. On the next edge:
  - out_data <= channel c data;
  - out_src <= c;
  - out_valid <= 1;
  - in round-robin mode only, rr_ptr <= (c+1) mod NUM_IN, wrapping from NUM_IN-1 to 0.
- Drain without refill: out_valid && out_ready with no transfer sets out_valid <= 0. out_data and out_src hold their last values.
- Stall: out_valid && !out_ready holds out_data, out_src and out_valid, and drives all in_ready bits low.
- Timing:
  - Latency is exactly 1 cycle from input transfer to out_valid.
  - Throughput is 1 beat/cycle with a simultaneous drain and refill.
- Mode/sel changes:
  - Sampled combinationally each cycle; take effect in the same cycle.
  - A held output beat is unaffected.
  - rr_ptr is retained across mode changes and updates only on round-robin transfers.
- Input rule: producers must hold in_data and in_valid stable until the transfer; the block does not check this.
- No combinational path from in_valid or in_data to the out_* ports. in_ready depends combinationally on out_ready, mode, sel, in_valid and rr_ptr.

Decomposition:
- Shared package (sel_mux_pkg):
  - MODE_EXPLICIT=1'b0 and MODE_RR=1'b1 constants;
  - default WIDTH=32.
- One natural sub-module, rr_pick: a combinational rotating-priority finder.
  - Inputs: NUM_IN valid bits and rr_ptr.
  - Outputs: found flag and index.
- The top level holds load_en, grant decode, the output register and rr_ptr.

Test Plan:
- Reset: assert reset for 2 cycles while in_valid=4'b1111 and out_ready=1 -> out_valid=0, out_data=0, out_src=0 and in_ready=0 during reset; first transfer occurs on the cycle after reset deasserts.
- Explicit mode: mode=0, sel=2, channel 2 = 32'hDEAD_BEEF, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100; next cycle out_data=32'hDEAD_BEEF, out_src=2, out_valid=1. Then set in_valid=0 -> out_valid drops to 0 one cycle later.
- Round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1, channel i data = i+100 -> out_src sequence 0,1,2,3,0,... one beat per cycle, with out_data = 100,101,102,103,100.
- Round-robin skip and wrap: rr_ptr=3 (after a grant to channel 2), in_valid=4'b0011 -> channel 0 granted, then channel 1. Afterwards set in_valid=4'b1000 -> channel 3 granted.
- Backpressure: out_valid=1 holding 32'h1234_5678 with out_ready=0 for 3 cycles and in_valid=4'b1111 -> out_data stable, in_ready=0 throughout. Raise out_ready -> same-cycle drain and refill; the next beat appears with no bubble.
- Mid-operation reset: reset asserted while out_valid=1 and stalled -> out_valid=0 after that edge and rr_ptr=0 (next round-robin grant goes to the lowest valid index).

Source files
------------

// File: rtl/sel_mux_pkg.sv
// Shared constants for the registered stream selector family.
package sel_mux_pkg;

  localparam logic MODE_EXPLICIT = 1'b0;
  localparam logic MODE_RR       = 1'b1;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority finder: first set valid bit scanning from ptr upward, wrapping.
// Latency: combinational. Backpressure: none, pure lookup.
// found=0 when no valid bit is set; idx is then 0.
module rr_pick #(
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] valid,
  input  logic [SEL_W-1:0]  ptr,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);

  int j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      // ptr is always < NUM_IN, so a single subtraction implements the wrap
      j = int'(ptr) + k;
      if (j >= NUM_IN) j = j - NUM_IN;
      if (!found && valid[j]) begin
        found = 1'b1;
        idx   = SEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/sel_stream_mux.sv
// N:1 valid/ready selector with a one-deep output register; explicit or round-robin select.
// Latency: 1 cycle from input transfer to out_valid; 1 beat/cycle with drain+refill.
// Backpressure: a stalled output beat drops every in_ready; a drain refills in the same cycle.
module sel_stream_mux
  import sel_mux_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic             load_en;
  logic             rr_found;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_next;
  logic             cand_found;
  logic [SEL_W-1:0] cand;
  logic [WIDTH-1:0] cand_data;
  logic             xfer;

  rr_pick #(.NUM_IN(NUM_IN)) u_rr_pick (
    .valid (in_valid),
    .ptr   (rr_ptr),
    .found (rr_found),
    .idx   (rr_idx)
  );

  assign load_en = !out_valid || out_ready;

  always_comb begin
    cand       = '0;
    cand_found = 1'b0;
    in_ready   = '0;
    if (mode == MODE_EXPLICIT) begin
      // sel can exceed NUM_IN-1 when NUM_IN is not a power of two
      cand       = sel;
      cand_found = (int'(sel) < NUM_IN);
    end else begin
      cand       = rr_idx;
      cand_found = rr_found;
    end
    if (!reset && load_en && cand_found) in_ready[cand] = 1'b1;
  end

  assign xfer      = !reset && load_en && cand_found && in_valid[cand];
  assign cand_data = in_data[int'(cand)*WIDTH +: WIDTH];
  assign rr_next   = (int'(cand) == NUM_IN - 1) ? '0 : cand + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_data  <= cand_data;
      out_src   <= cand;
      out_valid <= 1'b1;
      if (mode == MODE_RR) rr_ptr <= rr_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sel_stream_mux.sv
// Directed bench for sel_stream_mux (NUM_IN=4, WIDTH=32): reset, explicit, round-robin, backpressure.
module tb_sel_stream_mux;

  logic         clk = 1'b0;
  logic         reset;
  logic         mode;
  logic [1:0]   sel;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_src;
  logic         out_valid;
  logic         out_ready;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sel_stream_mux #(.WIDTH(32), .NUM_IN(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [31:0] d);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".out_src"}, {30'd0, out_src}, {30'd0, s});
    chk({tag, ".out_data"}, out_data, d);
  endtask

  task automatic set_default_data;
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'(i + 100);
  endtask

  initial begin
    reset     = 1'b1;
    mode      = 1'b0;
    sel       = 2'd0;
    set_default_data();
    in_valid  = 4'b1111;
    out_ready = 1'b1;

    // Reset held two cycles with every channel offering data
    #1;
    chk("rst_in_ready_pre", {28'd0, in_ready}, 32'd0);
    tick();
    chk_out("rst1", 1'b0, 2'd0, 32'd0);
    chk("rst1_in_ready", {28'd0, in_ready}, 32'd0);
    tick();
    chk_out("rst2", 1'b0, 2'd0, 32'd0);
    chk("rst2_in_ready", {28'd0, in_ready}, 32'd0);

    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", {28'd0, in_ready}, 32'h1);
    tick();
    chk_out("first_xfer", 1'b1, 2'd0, 32'd100);

    // Explicit select of channel 2
    sel = 2'd2;
    in_data[2*32 +: 32] = 32'hDEAD_BEEF;
    in_valid = 4'b0100;
    #1;
    chk("expl_in_ready", {28'd0, in_ready}, 32'h4);
    tick();
    chk_out("expl_beat", 1'b1, 2'd2, 32'hDEAD_BEEF);
    in_valid = 4'b0000;
    #1;
    chk("expl_ready_no_valid", {28'd0, in_ready}, 32'h4);
    tick();
    chk_out("expl_drain", 1'b0, 2'd2, 32'hDEAD_BEEF);

    // Round-robin fairness; explicit transfers left rr_ptr at 0
    set_default_data();
    mode = 1'b1;
    in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out($sformatf("rr_fair%0d", k), 1'b1, 2'(k % 4), 32'((k % 4) + 100));
    end

    // rr_ptr=1 here; grant ch2 moves it to 3, then 0 and 1 wrap, then 3
    in_valid = 4'b0100;
    tick();
    chk_out("rr_ch2", 1'b1, 2'd2, 32'd102);
    in_valid = 4'b0011;
    #1;
    chk("rr_wrap_in_ready", {28'd0, in_ready}, 32'h1);
    tick();
    chk_out("rr_wrap0", 1'b1, 2'd0, 32'd100);
    tick();
    chk_out("rr_wrap1", 1'b1, 2'd1, 32'd101);
    in_valid = 4'b1000;
    tick();
    chk_out("rr_ch3", 1'b1, 2'd3, 32'd103);

    // Backpressure: rr_ptr=0, load 1234_5678 from ch0, then stall 3 cycles
    in_data[0 +: 32] = 32'h1234_5678;
    in_valid = 4'b0001;
    tick();
    chk_out("bp_load", 1'b1, 2'd0, 32'h1234_5678);
    out_ready = 1'b0;
    in_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_in_ready%0d", k), {28'd0, in_ready}, 32'd0);
      tick();
      chk_out($sformatf("bp_hold%0d", k), 1'b1, 2'd0, 32'h1234_5678);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_refill_ready", {28'd0, in_ready}, 32'h2);
    tick();
    chk_out("bp_refill", 1'b1, 2'd1, 32'd101);

    // Mid-operation reset while stalled; rr_ptr would otherwise be 2
    out_ready = 1'b0;
    tick();
    chk_out("mid_stall", 1'b1, 2'd1, 32'd101);
    reset = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mid_rst_in_ready", {28'd0, in_ready}, 32'd0);
    tick();
    chk_out("mid_rst", 1'b0, 2'd0, 32'd0);
    reset = 1'b0;
    in_valid = 4'b0110;
    #1;
    chk("post_mid_in_ready", {28'd0, in_ready}, 32'h2);
    tick();
    chk_out("post_mid_beat", 1'b1, 2'd1, 32'd101);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
